// File: rtl/jk_pkg.sv
// Shared mode and JK-drive encodings for the JK modulo counter and its bit cells.
package jk_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // {J,K} drive codes for one storage bit
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_e;

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the JK modulo counter; master drives controls, slave is the counter.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;
    logic             at_limit;

    modport master (
        output en, mode, load_val,
        input  q, q_bar, tc, wrap, at_limit
    );

    modport slave (
        input  en, mode, load_val,
        output q, q_bar, tc, wrap, at_limit
    );
endinterface

// File: rtl/jk_bit_cell.sv
// One JK storage bit with synchronous active-high reset.
// Latency: 1 cycle from J/K to q; no backpressure.
module jk_bit_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            case (jk_code_e'({i_j, i_k}))
                JK_HOLD:   r_q <= r_q;
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jk_mod_counter.sv
// Modulo up/down/load counter with wrap or saturate at limits, built from JK bit cells.
// Latency: q/wrap/at_limit 1 cycle after en/mode sample, tc combinational; no backpressure.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    jk_mod_counter_if.slave  bus
);
    localparam logic [WIDTH:0]   LIM   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LIM_Q = LIM[WIDTH-1:0];

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_ld;
    logic             w_wrap_nxt;
    logic             w_lim_nxt;
    logic             r_wrap;
    logic             r_at_limit;

    // Extra top bit keeps the +1 overflow and -1 borrow visible even when MODULUS = 2**WIDTH
    assign w_inc = {1'b0, w_q} + (WIDTH+1)'(1);
    assign w_dec = {1'b0, w_q} - (WIDTH+1)'(1);
    assign w_ld  = {1'b0, bus.load_val};

    always_comb begin
        w_next     = w_q;
        w_wrap_nxt = 1'b0;
        w_lim_nxt  = r_at_limit;
        if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    if (w_inc <= LIM) begin
                        w_next    = w_inc[WIDTH-1:0];
                        w_lim_nxt = 1'b0;
                    end else if (SATURATE != 0) begin
                        w_lim_nxt = 1'b1;
                    end else begin
                        w_next     = '0;
                        w_wrap_nxt = 1'b1;
                        w_lim_nxt  = 1'b0;
                    end
                end
                MODE_DOWN: begin
                    if (!w_dec[WIDTH]) begin
                        w_next    = w_dec[WIDTH-1:0];
                        w_lim_nxt = 1'b0;
                    end else if (SATURATE != 0) begin
                        w_lim_nxt = 1'b1;
                    end else begin
                        w_next     = LIM_Q;
                        w_wrap_nxt = 1'b1;
                        w_lim_nxt  = 1'b0;
                    end
                end
                MODE_LOAD: begin
                    w_next    = (w_ld > LIM) ? LIM_Q : bus.load_val;
                    w_lim_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign w_j = w_next & ~w_q;
    assign w_k = ~w_next & w_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        jk_bit_cell u_cell (
            .clk (clk),
            .rst (rst),
            .i_j (w_j[b]),
            .i_k (w_k[b]),
            .o_q (w_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap     <= 1'b0;
            r_at_limit <= 1'b0;
        end else begin
            r_wrap     <= w_wrap_nxt;
            r_at_limit <= w_lim_nxt;
        end
    end

    assign bus.q        = w_q;
    assign bus.q_bar    = ~w_q;
    assign bus.wrap     = r_wrap;
    assign bus.at_limit = r_at_limit;
    assign bus.tc       = bus.en & (((bus.mode == MODE_UP)   && (w_q == LIM_Q)) ||
                                    ((bus.mode == MODE_DOWN) && (w_q == '0)));
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter in wrap (4b/10), saturate (4b/10) and full-range (3b/8) builds.
module tb_jk_mod_counter;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    jk_mod_counter_if #(.WIDTH(4)) a_if ();
    jk_mod_counter_if #(.WIDTH(4)) b_if ();
    jk_mod_counter_if #(.WIDTH(3)) c_if ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
    jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));
    jk_mod_counter #(.WIDTH(3), .MODULUS(8),  .SATURATE(0)) u_c (.clk(clk), .rst(rst_c), .bus(c_if));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic en, input logic [1:0] mode, input logic [3:0] ld);
        a_if.en = en; a_if.mode = mode; a_if.load_val = ld; #1;
    endtask

    task automatic drv_b(input logic en, input logic [1:0] mode, input logic [3:0] ld);
        b_if.en = en; b_if.mode = mode; b_if.load_val = ld; #1;
    endtask

    task automatic drv_c(input logic en, input logic [1:0] mode, input logic [2:0] ld);
        c_if.en = en; c_if.mode = mode; c_if.load_val = ld; #1;
    endtask

    int up_q    [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int up_tc   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drv_a(1'b0, MODE_HOLD, 4'd0);
        drv_b(1'b0, MODE_HOLD, 4'd0);
        drv_c(1'b0, MODE_HOLD, 3'd0);
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        chk("a_rst_q",     32'(a_if.q), 0);
        chk("a_rst_qbar",  32'(a_if.q_bar), 15);
        chk("a_rst_wrap",  32'(a_if.wrap), 0);
        chk("a_rst_lim",   32'(a_if.at_limit), 0);
        chk("b_rst_q",     32'(b_if.q), 0);
        chk("c_rst_q",     32'(c_if.q), 0);

        // reset in the middle of an up-count wins over en/mode
        drv_a(1'b1, MODE_UP, 4'd0);
        repeat (7) tick();
        chk("a_cnt7_q", 32'(a_if.q), 7);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("a_midrst_q",    32'(a_if.q), 0);
        chk("a_midrst_wrap", 32'(a_if.wrap), 0);
        chk("a_midrst_lim",  32'(a_if.at_limit), 0);

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("a_up_tc%0d", i), 32'(a_if.tc), 32'(up_tc[i]));
            tick();
            chk($sformatf("a_up_q%0d", i),    32'(a_if.q), 32'(up_q[i]));
            chk($sformatf("a_up_wrap%0d", i), 32'(a_if.wrap), 32'(up_wrap[i]));
        end
        chk("a_up_lim", 32'(a_if.at_limit), 0);

        drv_a(1'b1, MODE_LOAD, 4'd1);
        tick();
        chk("a_ld1_q", 32'(a_if.q), 1);
        drv_a(1'b1, MODE_DOWN, 4'd0);
        chk("a_dn_tc_q1", 32'(a_if.tc), 0);
        tick();
        chk("a_dn_q0", 32'(a_if.q), 0);
        chk("a_dn_tc_q0", 32'(a_if.tc), 1);
        tick();
        chk("a_dn_q9",    32'(a_if.q), 9);
        chk("a_dn_wrap9", 32'(a_if.wrap), 1);
        chk("a_dn_qbar9", 32'(a_if.q_bar), 6);
        chk("a_dn_tc_q9", 32'(a_if.tc), 0);
        tick();
        chk("a_dn_q8",    32'(a_if.q), 8);
        chk("a_dn_wrap8", 32'(a_if.wrap), 0);

        drv_a(1'b1, MODE_LOAD, 4'd5);
        tick();
        chk("a_ld5_q", 32'(a_if.q), 5);
        drv_a(1'b1, MODE_LOAD, 4'd14);
        tick();
        chk("a_ld14_q",    32'(a_if.q), 9);
        chk("a_ld14_wrap", 32'(a_if.wrap), 0);
        drv_a(1'b0, MODE_LOAD, 4'd3);
        tick();
        chk("a_en0_ld_q", 32'(a_if.q), 9);
        drv_a(1'b0, MODE_UP, 4'd0);
        chk("a_en0_tc", 32'(a_if.tc), 0);
        tick();
        chk("a_en0_up_q", 32'(a_if.q), 9);
        drv_a(1'b1, MODE_HOLD, 4'd0);
        chk("a_hold_tc", 32'(a_if.tc), 0);
        tick();
        chk("a_hold_q", 32'(a_if.q), 9);

        // saturating build: pin at 9, then step back down
        drv_b(1'b1, MODE_UP, 4'd0);
        repeat (9) tick();
        chk("b_up9_q",   32'(b_if.q), 9);
        chk("b_up9_lim", 32'(b_if.at_limit), 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b_sat_tc%0d", i), 32'(b_if.tc), 1);
            tick();
            chk($sformatf("b_sat_q%0d", i),    32'(b_if.q), 9);
            chk($sformatf("b_sat_lim%0d", i),  32'(b_if.at_limit), 1);
            chk($sformatf("b_sat_wrap%0d", i), 32'(b_if.wrap), 0);
        end
        drv_b(1'b0, MODE_UP, 4'd0);
        tick();
        chk("b_en0_lim_held", 32'(b_if.at_limit), 1);
        drv_b(1'b1, MODE_DOWN, 4'd0);
        tick();
        chk("b_dn_q8",   32'(b_if.q), 8);
        chk("b_dn_lim8", 32'(b_if.at_limit), 0);
        drv_b(1'b1, MODE_LOAD, 4'd0);
        tick();
        drv_b(1'b1, MODE_DOWN, 4'd0);
        tick();
        chk("b_satlo_q",    32'(b_if.q), 0);
        chk("b_satlo_lim",  32'(b_if.at_limit), 1);
        chk("b_satlo_wrap", 32'(b_if.wrap), 0);
        drv_b(1'b1, MODE_LOAD, 4'd4);
        tick();
        chk("b_ld4_q",   32'(b_if.q), 4);
        chk("b_ld4_lim", 32'(b_if.at_limit), 0);

        // full-range build: MODULUS = 2**WIDTH
        drv_c(1'b1, MODE_LOAD, 3'd7);
        tick();
        chk("c_ld7_q", 32'(c_if.q), 7);
        drv_c(1'b1, MODE_UP, 3'd0);
        chk("c_up_tc", 32'(c_if.tc), 1);
        tick();
        chk("c_up_q0",    32'(c_if.q), 0);
        chk("c_up_wrap",  32'(c_if.wrap), 1);
        chk("c_up_qbar",  32'(c_if.q_bar), 7);
        drv_c(1'b1, MODE_DOWN, 3'd0);
        chk("c_dn_tc", 32'(c_if.tc), 1);
        tick();
        chk("c_dn_q7",    32'(c_if.q), 7);
        chk("c_dn_wrap",  32'(c_if.wrap), 1);
        chk("c_dn_qbar",  32'(c_if.q_bar), 0);
        tick();
        chk("c_dn_q6",    32'(c_if.q), 6);
        chk("c_dn_wrap6", 32'(c_if.wrap), 0);
        chk("c_dn_qbar6", 32'(c_if.q_bar), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
